// File: rtl/lpgbt_uplink_link_ctrl_if.sv
// Control/status bundle between the uplink link sequencer and its surroundings.
// The sequencer sits on the slave side; the driver (supervisor or bench) sits on the master side.
interface lpgbt_uplink_link_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             enable_i;
    logic             restart_i;
    logic             polarity_auto_i;
    logic             polarity_init_i;
    logic             clear_cnt_i;
    logic             mgt_rx_rdy_i;
    logic             uplinkrdy_i;
    logic             uplinkFEC_i;
    logic             uplinkRst_o;
    logic             mgt_rxpolarity_o;
    logic [2:0]       state_o;
    logic             locked_o;
    logic             failed_o;
    logic [3:0]       retry_cnt_o;
    logic [CNT_W-1:0] lock_loss_cnt_o;
    logic [CNT_W-1:0] fec_cnt_o;

    modport slave (
        input  enable_i, restart_i, polarity_auto_i, polarity_init_i, clear_cnt_i,
               mgt_rx_rdy_i, uplinkrdy_i, uplinkFEC_i,
        output uplinkRst_o, mgt_rxpolarity_o, state_o, locked_o, failed_o,
               retry_cnt_o, lock_loss_cnt_o, fec_cnt_o
    );

    modport master (
        output enable_i, restart_i, polarity_auto_i, polarity_init_i, clear_cnt_i,
               mgt_rx_rdy_i, uplinkrdy_i, uplinkFEC_i,
        input  uplinkRst_o, mgt_rxpolarity_o, state_o, locked_o, failed_o,
               retry_cnt_o, lock_loss_cnt_o, fec_cnt_o
    );
endinterface

// File: rtl/lpgbt_uplink_link_ctrl.sv
// Bring-up and supervision sequencer for the lpGBT-FPGA uplink (recovered 40 MHz domain).
// Drives uplink reset and RX polarity, retries on timeout, counts lock losses and FEC events.
module lpgbt_uplink_link_ctrl #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 40000,
    parameter int STABLE_CYCLES = 256,
    parameter int MAX_RETRIES   = 8,
    parameter int CNT_W         = 16
) (
    input  logic                    clk40_i,
    input  logic                    rst_i,
    lpgbt_uplink_link_ctrl_if.slave lnk
);

    // One timer serves both the reset pulse and the lock timeout.
    localparam int TMR_MAX = (LOCK_TIMEOUT > RST_CYCLES) ? LOCK_TIMEOUT : RST_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int STB_W   = $clog2(STABLE_CYCLES + 1);

    localparam logic [TMR_W-1:0] RST_LAST  = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] TO_LAST   = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [STB_W-1:0] STB_LAST  = STB_W'(STABLE_CYCLES - 1);
    localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESET     = 3'd1,
        ST_WAIT_MGT  = 3'd2,
        ST_WAIT_LOCK = 3'd3,
        ST_STABLE    = 3'd4,
        ST_LOCKED    = 3'd5,
        ST_FAILED    = 3'd6
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == {CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

    state_t           state_r, state_nxt_s, retry_state_s;
    logic [TMR_W-1:0] timer_r, timer_nxt_s;
    logic [STB_W-1:0] stable_r, stable_nxt_s;
    logic [3:0]       retry_cnt_r, retry_nxt_s, retry_inc_s;
    logic             pol_r, pol_nxt_s, retry_pol_s;
    logic             uplink_rst_r, locked_r, failed_r;
    logic             lock_loss_inc_s, fec_inc_s;
    logic [CNT_W-1:0] lock_loss_cnt_r, fec_cnt_r;

    // Next-state, timers and retry bookkeeping.
    always_comb begin
        state_nxt_s     = state_r;
        timer_nxt_s     = {TMR_W{1'b0}};
        stable_nxt_s    = {STB_W{1'b0}};
        retry_nxt_s     = retry_cnt_r;
        pol_nxt_s       = pol_r;
        lock_loss_inc_s = 1'b0;
        fec_inc_s       = (state_r == ST_LOCKED) && lnk.uplinkFEC_i;
        retry_inc_s     = RETRY_MAX;
        retry_state_s   = ST_RESET;
        retry_pol_s     = pol_r;

        if (retry_cnt_r >= RETRY_MAX) begin
            retry_inc_s = RETRY_MAX;
        end else begin
            retry_inc_s = retry_cnt_r + 4'd1;
        end

        // A failed attempt either gives up or retries, optionally with flipped polarity.
        if (retry_inc_s == RETRY_MAX) begin
            retry_state_s = ST_FAILED;
            retry_pol_s   = pol_r;
        end else if (lnk.polarity_auto_i) begin
            retry_state_s = ST_RESET;
            retry_pol_s   = ~pol_r;
        end else begin
            retry_state_s = ST_RESET;
            retry_pol_s   = pol_r;
        end

        if (!lnk.enable_i) begin
            state_nxt_s = ST_IDLE;
            retry_nxt_s = 4'd0;
        end else if (lnk.restart_i && (state_r != ST_IDLE)) begin
            state_nxt_s = ST_RESET;
            retry_nxt_s = 4'd0;
            pol_nxt_s   = lnk.polarity_init_i;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_RESET;
                    retry_nxt_s = 4'd0;
                    pol_nxt_s   = lnk.polarity_init_i;
                end
                ST_RESET: begin
                    if (timer_r == RST_LAST) begin
                        state_nxt_s = ST_WAIT_MGT;
                    end else begin
                        timer_nxt_s = timer_r + TMR_W'(1);
                    end
                end
                ST_WAIT_MGT: begin
                    if (timer_r == TO_LAST) begin
                        state_nxt_s = retry_state_s;
                        pol_nxt_s   = retry_pol_s;
                        retry_nxt_s = retry_inc_s;
                    end else if (lnk.mgt_rx_rdy_i) begin
                        state_nxt_s = ST_WAIT_LOCK;
                        timer_nxt_s = timer_r + TMR_W'(1);
                    end else begin
                        timer_nxt_s = timer_r + TMR_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (timer_r == TO_LAST) begin
                        state_nxt_s = retry_state_s;
                        pol_nxt_s   = retry_pol_s;
                        retry_nxt_s = retry_inc_s;
                    end else if (lnk.uplinkrdy_i) begin
                        state_nxt_s = ST_STABLE;
                    end else begin
                        timer_nxt_s = timer_r + TMR_W'(1);
                    end
                end
                ST_STABLE: begin
                    if (!lnk.uplinkrdy_i || !lnk.mgt_rx_rdy_i) begin
                        state_nxt_s = retry_state_s;
                        pol_nxt_s   = retry_pol_s;
                        retry_nxt_s = retry_inc_s;
                    end else if (stable_r == STB_LAST) begin
                        state_nxt_s = ST_LOCKED;
                        retry_nxt_s = 4'd0;
                    end else begin
                        stable_nxt_s = stable_r + STB_W'(1);
                    end
                end
                ST_LOCKED: begin
                    if (!lnk.uplinkrdy_i || !lnk.mgt_rx_rdy_i) begin
                        state_nxt_s     = ST_RESET;
                        lock_loss_inc_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_LOCKED;
                    end
                end
                ST_FAILED: begin
                    state_nxt_s = ST_FAILED;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    retry_nxt_s = 4'd0;
                end
            endcase
        end
    end

    // State register and outputs registered from the next state.
    always_ff @(posedge clk40_i) begin
        if (rst_i) begin
            state_r      <= ST_IDLE;
            timer_r      <= {TMR_W{1'b0}};
            stable_r     <= {STB_W{1'b0}};
            retry_cnt_r  <= 4'd0;
            pol_r        <= 1'b0;
            uplink_rst_r <= 1'b1;
            locked_r     <= 1'b0;
            failed_r     <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            timer_r      <= timer_nxt_s;
            stable_r     <= stable_nxt_s;
            retry_cnt_r  <= retry_nxt_s;
            pol_r        <= pol_nxt_s;
            uplink_rst_r <= (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_RESET) ||
                            (state_nxt_s == ST_FAILED);
            locked_r     <= (state_nxt_s == ST_LOCKED);
            failed_r     <= (state_nxt_s == ST_FAILED);
        end
    end

    // Saturating event counters; a clear wins over a same-cycle increment.
    always_ff @(posedge clk40_i) begin
        if (rst_i) begin
            lock_loss_cnt_r <= {CNT_W{1'b0}};
            fec_cnt_r       <= {CNT_W{1'b0}};
        end else if (lnk.clear_cnt_i) begin
            lock_loss_cnt_r <= {CNT_W{1'b0}};
            fec_cnt_r       <= {CNT_W{1'b0}};
        end else begin
            lock_loss_cnt_r <= lock_loss_inc_s ? sat_inc(lock_loss_cnt_r) : lock_loss_cnt_r;
            fec_cnt_r       <= fec_inc_s ? sat_inc(fec_cnt_r) : fec_cnt_r;
        end
    end

    assign lnk.uplinkRst_o      = uplink_rst_r;
    assign lnk.mgt_rxpolarity_o = pol_r;
    assign lnk.state_o          = state_r;
    assign lnk.locked_o         = locked_r;
    assign lnk.failed_o         = failed_r;
    assign lnk.retry_cnt_o      = retry_cnt_r;
    assign lnk.lock_loss_cnt_o  = lock_loss_cnt_r;
    assign lnk.fec_cnt_o        = fec_cnt_r;

endmodule

// File: tb/tb_lpgbt_uplink_link_ctrl.sv
// Directed bench for the uplink link sequencer: bring-up, retries, glitch, lock loss,
// counter clear/saturation and reset/enable priority, with hand-computed expectations.
module tb_lpgbt_uplink_link_ctrl;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    lpgbt_uplink_link_ctrl_if #(.CNT_W(4)) lnk ();

    lpgbt_uplink_link_ctrl #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (100),
        .STABLE_CYCLES(8),
        .MAX_RETRIES  (3),
        .CNT_W        (4)
    ) dut (
        .clk40_i(clk),
        .rst_i  (rst),
        .lnk    (lnk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] target, input int budget, input string tag);
        int k;
        k = 0;
        while ((lnk.state_o != target) && (k < budget)) begin
            tick(1);
            k++;
        end
        check(tag, {29'd0, lnk.state_o}, {29'd0, target});
    endtask

    // One timed-out attempt: 100 cycles across WAIT_MGT/WAIT_LOCK, then the retry outcome.
    task automatic timeout_attempt(input logic [2:0] exp_state, input logic [3:0] exp_retry,
                                   input logic exp_pol, input string tag);
        int n;
        n = 0;
        wait_state(3'd2, 10, {tag, "_enter"});
        n = 1;
        while (((lnk.state_o == 3'd2) || (lnk.state_o == 3'd3)) && (n < 200)) begin
            tick(1);
            if ((lnk.state_o == 3'd2) || (lnk.state_o == 3'd3)) n++;
        end
        check({tag, "_len"}, n, 32'd100);
        check({tag, "_state"}, {29'd0, lnk.state_o}, {29'd0, exp_state});
        check({tag, "_retry"}, {28'd0, lnk.retry_cnt_o}, {28'd0, exp_retry});
        check({tag, "_pol"}, {31'd0, lnk.mgt_rxpolarity_o}, {31'd0, exp_pol});
    endtask

    initial begin
        int n;
        n_assert = 0;
        n_fail   = 0;
        rst = 1'b1;
        lnk.enable_i        = 1'b0;
        lnk.restart_i       = 1'b0;
        lnk.polarity_auto_i = 1'b0;
        lnk.polarity_init_i = 1'b0;
        lnk.clear_cnt_i     = 1'b0;
        lnk.mgt_rx_rdy_i    = 1'b0;
        lnk.uplinkrdy_i     = 1'b0;
        lnk.uplinkFEC_i     = 1'b0;
        tick(2);

        check("rst_state",  {29'd0, lnk.state_o}, 32'd0);
        check("rst_urst",   {31'd0, lnk.uplinkRst_o}, 32'd1);
        check("rst_pol",    {31'd0, lnk.mgt_rxpolarity_o}, 32'd0);
        check("rst_locked", {31'd0, lnk.locked_o}, 32'd0);
        check("rst_failed", {31'd0, lnk.failed_o}, 32'd0);
        check("rst_retry",  {28'd0, lnk.retry_cnt_o}, 32'd0);
        check("rst_ll",     {28'd0, lnk.lock_loss_cnt_o}, 32'd0);
        check("rst_fec",    {28'd0, lnk.fec_cnt_o}, 32'd0);

        // Nominal bring-up with initial polarity 1.
        rst = 1'b0;
        lnk.polarity_init_i = 1'b1;
        lnk.enable_i        = 1'b1;
        tick(1);
        check("up_reset", {29'd0, lnk.state_o}, 32'd1);
        check("up_pol0",  {31'd0, lnk.mgt_rxpolarity_o}, 32'd1);
        n = 1;
        while ((lnk.state_o == 3'd1) && (n < 20)) begin
            tick(1);
            if ((lnk.state_o == 3'd1) && lnk.uplinkRst_o) n++;
        end
        check("up_rst_len", n, 32'd4);
        check("up_wmgt",    {29'd0, lnk.state_o}, 32'd2);
        check("up_urst0",   {31'd0, lnk.uplinkRst_o}, 32'd0);
        tick(9);
        lnk.mgt_rx_rdy_i = 1'b1;
        tick(1);
        check("up_wlock", {29'd0, lnk.state_o}, 32'd3);
        tick(19);
        lnk.uplinkrdy_i = 1'b1;
        tick(1);
        check("up_stable", {29'd0, lnk.state_o}, 32'd4);
        tick(7);
        check("up_stable7", {29'd0, lnk.state_o}, 32'd4);
        check("up_nolock",  {31'd0, lnk.locked_o}, 32'd0);
        tick(1);
        check("up_locked_st", {29'd0, lnk.state_o}, 32'd5);
        check("up_locked",    {31'd0, lnk.locked_o}, 32'd1);
        check("up_pol1",      {31'd0, lnk.mgt_rxpolarity_o}, 32'd1);

        // Three FEC pulses then a lock loss.
        for (int i = 0; i < 3; i++) begin
            lnk.uplinkFEC_i = 1'b1;
            tick(1);
            lnk.uplinkFEC_i = 1'b0;
            tick(1);
        end
        check("fec3", {28'd0, lnk.fec_cnt_o}, 32'd3);
        lnk.uplinkrdy_i = 1'b0;
        tick(1);
        check("loss_state", {29'd0, lnk.state_o}, 32'd1);
        check("loss_ll",    {28'd0, lnk.lock_loss_cnt_o}, 32'd1);
        check("loss_pol",   {31'd0, lnk.mgt_rxpolarity_o}, 32'd1);
        check("loss_retry", {28'd0, lnk.retry_cnt_o}, 32'd0);
        check("loss_fec",   {28'd0, lnk.fec_cnt_o}, 32'd3);

        // Glitch in STABLE at count 5.
        lnk.uplinkrdy_i = 1'b1;
        wait_state(3'd4, 40, "gl_stable");
        tick(5);
        check("gl_still", {29'd0, lnk.state_o}, 32'd4);
        lnk.uplinkrdy_i = 1'b0;
        tick(1);
        lnk.uplinkrdy_i = 1'b1;
        check("gl_state", {29'd0, lnk.state_o}, 32'd1);
        check("gl_retry", {28'd0, lnk.retry_cnt_o}, 32'd1);
        check("gl_ll",    {28'd0, lnk.lock_loss_cnt_o}, 32'd1);
        check("gl_pol",   {31'd0, lnk.mgt_rxpolarity_o}, 32'd1);
        wait_state(3'd5, 40, "relock");
        check("relock_retry", {28'd0, lnk.retry_cnt_o}, 32'd0);

        // Clear beats a same-cycle FEC increment, then saturate fec at 15.
        lnk.clear_cnt_i = 1'b1;
        lnk.uplinkFEC_i = 1'b1;
        tick(1);
        lnk.clear_cnt_i = 1'b0;
        check("clr_fec", {28'd0, lnk.fec_cnt_o}, 32'd0);
        check("clr_ll",  {28'd0, lnk.lock_loss_cnt_o}, 32'd0);
        tick(1);
        check("sat_fec1", {28'd0, lnk.fec_cnt_o}, 32'd1);
        tick(19);
        lnk.uplinkFEC_i = 1'b0;
        check("sat_fec15", {28'd0, lnk.fec_cnt_o}, 32'd15);

        // Timeouts with auto polarity, starting from polarity 0.
        lnk.polarity_init_i = 1'b0;
        lnk.polarity_auto_i = 1'b1;
        lnk.uplinkrdy_i     = 1'b0;
        lnk.restart_i       = 1'b1;
        tick(1);
        lnk.restart_i = 1'b0;
        check("to_restart", {29'd0, lnk.state_o}, 32'd1);
        check("to_pol0",    {31'd0, lnk.mgt_rxpolarity_o}, 32'd0);
        timeout_attempt(3'd1, 4'd1, 1'b1, "to1");
        timeout_attempt(3'd1, 4'd2, 1'b0, "to2");
        timeout_attempt(3'd6, 4'd3, 1'b0, "to3");
        check("to_failed", {31'd0, lnk.failed_o}, 32'd1);
        check("to_urst",   {31'd0, lnk.uplinkRst_o}, 32'd1);
        tick(5);
        check("to_hold", {29'd0, lnk.state_o}, 32'd6);
        lnk.restart_i = 1'b1;
        tick(1);
        lnk.restart_i = 1'b0;
        check("rs_state",  {29'd0, lnk.state_o}, 32'd1);
        check("rs_retry",  {28'd0, lnk.retry_cnt_o}, 32'd0);
        check("rs_failed", {31'd0, lnk.failed_o}, 32'd0);

        // Synchronous reset in the middle of WAIT_LOCK after one retry.
        timeout_attempt(3'd1, 4'd1, 1'b1, "pre_rst");
        wait_state(3'd3, 20, "mid_wlock");
        tick(5);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("r6_state", {29'd0, lnk.state_o}, 32'd0);
        check("r6_urst",  {31'd0, lnk.uplinkRst_o}, 32'd1);
        check("r6_retry", {28'd0, lnk.retry_cnt_o}, 32'd0);
        check("r6_fec",   {28'd0, lnk.fec_cnt_o}, 32'd0);
        check("r6_ll",    {28'd0, lnk.lock_loss_cnt_o}, 32'd0);
        check("r6_pol",   {31'd0, lnk.mgt_rxpolarity_o}, 32'd0);

        // enable_i=0 outranks a simultaneous restart.
        tick(1);
        check("en_reset", {29'd0, lnk.state_o}, 32'd1);
        tick(2);
        lnk.enable_i  = 1'b0;
        lnk.restart_i = 1'b1;
        tick(1);
        lnk.restart_i = 1'b0;
        check("en_idle", {29'd0, lnk.state_o}, 32'd0);
        check("en_urst", {31'd0, lnk.uplinkRst_o}, 32'd1);
        tick(1);
        check("en_hold", {29'd0, lnk.state_o}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
